// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 16-bit-instruction CPU core.
// Fetches instructions and accesses data memory over independent req/ack handshakes.
// A stalling memory simply holds ack low; the request and its address stay stable meanwhile.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   o_imem_req/addr, i_imem_ack/data  instruction fetch handshake (addr = PC)
//   o_dmem_req/we/addr/wdata          data access request (addr = ra, wdata = rb)
//   i_dmem_ack/rdata                  data access completion, read data
//   o_pc                              current PC
//   o_halted                          core stopped on an undefined opcode
module multicycle_core #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned INST_ADDR_WIDTH = 8,
   parameter int unsigned DATA_ADDR_WIDTH = 8,
   parameter int unsigned RESET_PC        = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   output logic                       o_imem_req,
   output logic [INST_ADDR_WIDTH-1:0] o_imem_addr,
   input  logic                       i_imem_ack,
   input  logic [15:0]                i_imem_data,
   output logic                       o_dmem_req,
   output logic                       o_dmem_we,
   output logic [DATA_ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
   input  logic                       i_dmem_ack,
   input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
   output logic [INST_ADDR_WIDTH-1:0] o_pc,
   output logic                       o_halted
);

   localparam int unsigned ShiftW = $clog2(DATA_WIDTH);
   localparam logic [INST_ADDR_WIDTH-1:0] ResetPc = INST_ADDR_WIDTH'(RESET_PC);

   // Instruction set encoding; 0xA..0xF are the undefined opcodes.
   localparam logic [3:0] OpAdd   = 4'h0;
   localparam logic [3:0] OpSub   = 4'h1;
   localparam logic [3:0] OpAnd   = 4'h2;
   localparam logic [3:0] OpOr    = 4'h3;
   localparam logic [3:0] OpShift = 4'h4;
   localparam logic [3:0] OpMove  = 4'h5;
   localparam logic [3:0] OpLoadc = 4'h6;
   localparam logic [3:0] OpJump  = 4'h7;
   localparam logic [3:0] OpLoad  = 4'h8;
   localparam logic [3:0] OpStore = 4'h9;

   typedef enum logic [1:0] {StFetch, StExecute, StMem, StHalt} state_e;

   state_e                     state_q, state_d;
   logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]                ir_q, ir_d;
   logic [DATA_WIDTH-1:0]      regs_q [4];
   logic [DATA_WIDTH-1:0]      regs_d [4];
   logic [DATA_ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0]      mwdata_q, mwdata_d;
   logic                       mwe_q, mwe_d;

   logic [3:0]                 op;
   logic [1:0]                 hi;
   logic [1:0]                 lo;
   logic [DATA_WIDTH-1:0]      k_ext;
   logic [DATA_WIDTH-1:0]      alu_a;
   logic [DATA_WIDTH-1:0]      alu_b;
   logic [DATA_WIDTH-1:0]      reg_hi;
   logic [ShiftW-1:0]          shamt;
   logic [DATA_WIDTH-1:0]      alu_res;
   logic [INST_ADDR_WIDTH-1:0] pc_inc;

   assign op     = ir_q[15:12];
   assign hi     = ir_q[11:10];
   assign lo     = ir_q[9:8];
   assign k_ext  = {{(DATA_WIDTH-8){1'b0}}, ir_q[7:0]};
   assign alu_a  = lo[1] ? regs_q[1] : regs_q[0];
   assign alu_b  = lo[0] ? k_ext : regs_q[2];
   assign reg_hi = regs_q[hi];
   assign shamt  = lo[1] ? k_ext[ShiftW-1:0] : regs_q[3][ShiftW-1:0];
   assign pc_inc = pc_q + INST_ADDR_WIDTH'(1);

   always_comb begin
      alu_res = '0;
      case (op)
         OpAdd:   alu_res = alu_a + alu_b;
         OpSub:   alu_res = alu_a - alu_b;
         OpAnd:   alu_res = alu_a & alu_b;
         OpOr:    alu_res = alu_a | alu_b;
         OpShift: alu_res = lo[0] ? (reg_hi >> shamt) : (reg_hi << shamt);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      regs_d   = regs_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      mwe_d    = mwe_q;
      unique case (state_q)
         StFetch: begin
            if (i_imem_ack) begin
               ir_d    = i_imem_data;
               state_d = StExecute;
            end
         end
         StExecute: begin
            state_d = StFetch;
            pc_d    = pc_inc;
            case (op)
               OpAdd, OpSub, OpAnd, OpOr, OpShift: regs_d[hi] = alu_res;
               OpMove: regs_d[hi] = regs_q[lo];
               OpLoadc: begin
                  if (lo[0]) begin
                     regs_d[hi][15:8] = ir_q[7:0];
                  end else begin
                     regs_d[hi] = k_ext;
                  end
               end
               OpJump: pc_d = regs_q[0][INST_ADDR_WIDTH-1:0];
               OpLoad, OpStore: begin
                  // PC advances only once the access completes.
                  pc_d     = pc_q;
                  state_d  = StMem;
                  maddr_d  = regs_q[0][DATA_ADDR_WIDTH-1:0];
                  mwdata_d = regs_q[1];
                  mwe_d    = (op == OpStore);
               end
               default: begin
                  pc_d    = pc_q;
                  state_d = StHalt;
               end
            endcase
         end
         StMem: begin
            if (i_dmem_ack) begin
               if (!mwe_q) begin
                  regs_d[hi] = i_dmem_rdata;
               end
               pc_d    = pc_inc;
               state_d = StFetch;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StFetch;
         pc_q     <= ResetPc;
         ir_q     <= '0;
         regs_q   <= '{default: '0};
         maddr_q  <= '0;
         mwdata_q <= '0;
         mwe_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         regs_q   <= regs_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mwe_q    <= mwe_d;
      end
   end

   // Reset forces state to StFetch, so requests are gated to stay low while reset is held.
   assign o_imem_req   = (state_q == StFetch) && !i_rst;
   assign o_imem_addr  = pc_q;
   assign o_dmem_req   = (state_q == StMem) && !i_rst;
   assign o_dmem_we    = o_dmem_req && mwe_q;
   assign o_dmem_addr  = maddr_q;
   assign o_dmem_wdata = mwdata_q;
   assign o_pc         = pc_q;
   assign o_halted     = (state_q == StHalt) && !i_rst;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench for multicycle_core.
// A responder serves instruction/data memories with programmable wait states; each delivered
// instruction is executed by an ISA-level model that queues the expected next fetch address and
// any data access. A monitor pops and compares whenever the DUT completes a handshake.
module tb_multicycle_core;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SHIFT = 4, OP_MOVE = 5;
   localparam int OP_LOADC = 6, OP_JUMP = 7, OP_LOAD = 8, OP_STORE = 9;

   typedef struct {int addr; int lat;} fetch_t;
   typedef struct {bit we; int addr; int data;} dacc_t;

   logic        i_clk;
   logic        i_rst;
   logic        o_imem_req;
   logic [7:0]  o_imem_addr;
   logic        im_ack = 1'b0;
   logic [15:0] im_data = 16'h0;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [7:0]  o_dmem_addr;
   logic [15:0] o_dmem_wdata;
   logic        dm_ack = 1'b0;
   logic        force_ack = 1'b0;
   logic [15:0] dm_rdata = 16'h0;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic [7:0]  o_pc;
   logic        o_halted;

   assign dmem_ack   = dm_ack | force_ack;
   assign dmem_rdata = force_ack ? 16'hDEAD : dm_rdata;

   multicycle_core #(
      .DATA_WIDTH(16),
      .INST_ADDR_WIDTH(8),
      .DATA_ADDR_WIDTH(8),
      .RESET_PC(0)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .o_imem_req(o_imem_req),
      .o_imem_addr(o_imem_addr),
      .i_imem_ack(im_ack),
      .i_imem_data(im_data),
      .o_dmem_req(o_dmem_req),
      .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_ack(dmem_ack),
      .i_dmem_rdata(dmem_rdata),
      .o_pc(o_pc),
      .o_halted(o_halted)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          errors = 0;
   int          delivered = 0;
   int          limit = 0;
   int          wait_mode = 0;  // 0 random, 1 zero wait, 2 fixed 3, 3 dmem 12
   longint      cyc = 0;
   logic [15:0] imem [256];
   logic [15:0] pmem [256];
   int          m_mem [256];
   int          m_r [4];
   int          m_pc;
   bit          m_halted;
   fetch_t      fetch_q [$];
   dacc_t       dacc_q [$];

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rand_instr();
      int          tbl [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 6, 4};
      logic [15:0] ins;
      ins        = 16'($urandom);
      ins[15:12] = 4'(tbl[$urandom_range(0, 12)]);
      return ins;
   endfunction

   function automatic int pick_wait(input bit is_dmem);
      case (wait_mode)
         0:       return $urandom_range(0, 3);
         1:       return 0;
         2:       return 3;
         default: return is_dmem ? 12 : 0;
      endcase
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_pc      = 0;
      m_halted  = 0;
      delivered = 0;
      fetch_q.delete();
      dacc_q.delete();
      fetch_q.push_back('{0, 0});
   endtask

   // ISA-level execution of one instruction.
   task automatic model_step(input logic [15:0] ins);
      int op, hi, lo, k, a, b, amt, npc, lat, addr;
      op  = int'(ins[15:12]);
      hi  = int'(ins[11:10]);
      lo  = int'(ins[9:8]);
      k   = int'(ins[7:0]);
      npc = (m_pc + 1) % 256;
      lat = 2;
      a   = (lo >= 2) ? m_r[1] : m_r[0];
      b   = (lo % 2 == 1) ? k : m_r[2];
      addr = m_r[0] % 256;
      case (op)
         OP_ADD:   m_r[hi] = (a + b) % 65536;
         OP_SUB:   m_r[hi] = (a - b + 65536) % 65536;
         OP_AND:   m_r[hi] = a & b;
         OP_OR:    m_r[hi] = a | b;
         OP_SHIFT: begin
            amt = ((lo >= 2) ? k : m_r[3]) % 16;
            if (lo % 2 == 0) m_r[hi] = int'((longint'(m_r[hi]) * (longint'(1) << amt)) % 65536);
            else             m_r[hi] = m_r[hi] / (1 << amt);
         end
         OP_MOVE:  m_r[hi] = m_r[lo];
         OP_LOADC: m_r[hi] = (lo % 2 == 0) ? k : (m_r[hi] % 256) + k * 256;
         OP_JUMP:  npc = m_r[0] % 256;
         OP_LOAD: begin
            dacc_q.push_back('{1'b0, addr, 0});
            m_r[hi] = m_mem[addr];
            lat = 3;
         end
         OP_STORE: begin
            dacc_q.push_back('{1'b1, addr, m_r[1]});
            m_mem[addr] = m_r[1];
            lat = 3;
         end
         default:  m_halted = 1;
      endcase
      if (!m_halted) begin
         m_pc = npc;
         fetch_q.push_back('{npc, (wait_mode == 1) ? lat : 0});
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   // Memory responder: decides acks just after each edge.
   int im_cnt = 0, im_wait = 0, dm_cnt = 0, dm_wait = 0;
   always @(posedge i_clk) begin
      #1;
      if (i_rst) begin
         im_ack = 1'b0;
         dm_ack = 1'b0;
         im_cnt = 0;
         dm_cnt = 0;
      end else begin
         im_ack = 1'b0;
         dm_ack = 1'b0;
         if (o_imem_req && delivered < limit) begin
            if (im_cnt == 0) im_wait = pick_wait(1'b0);
            if (im_cnt >= im_wait) begin
               im_data = imem[o_imem_addr];
               im_ack  = 1'b1;
               im_cnt  = 0;
               delivered++;
               model_step(im_data);
            end else begin
               im_cnt++;
               im_data = 16'($urandom);
            end
         end
         if (o_dmem_req) begin
            if (dm_cnt == 0) dm_wait = pick_wait(1'b1);
            if (dm_cnt >= dm_wait) begin
               dm_ack = 1'b1;
               dm_cnt = 0;
               if (o_dmem_we) pmem[o_dmem_addr] = o_dmem_wdata;
               else           dm_rdata = pmem[o_dmem_addr];
            end else begin
               dm_cnt++;
               dm_rdata = 16'($urandom);
            end
         end
      end
   end

   // Monitor / scoreboard.
   bit          prev_ireq = 0, prev_dreq = 0, prev_dwe = 0;
   logic [7:0]  prev_iaddr = '0, prev_daddr = '0;
   logic [15:0] prev_dwdata = '0;
   longint      last_fc = -1;
   always @(negedge i_clk) begin
      fetch_t fe;
      dacc_t  de;
      if (i_rst) begin
         prev_ireq = 0;
         prev_dreq = 0;
         last_fc   = -1;
      end else begin
         if (o_imem_req && o_dmem_req) check(1'b0, "one_req_at_a_time", 1, 0);
         if (o_imem_req && prev_ireq)
            check(o_imem_addr == prev_iaddr, "imem_addr_stable", o_imem_addr, prev_iaddr);
         if (o_dmem_req && prev_dreq)
            check(o_dmem_addr == prev_daddr && o_dmem_we == prev_dwe &&
                  o_dmem_wdata == prev_dwdata, "dmem_req_stable", o_dmem_addr, prev_daddr);
         if (o_imem_req && im_ack) begin
            if (fetch_q.size() == 0) begin
               check(1'b0, "fetch_unexpected", o_imem_addr, 0);
            end else begin
               fe = fetch_q.pop_front();
               check(int'(o_imem_addr) == fe.addr, "fetch_addr", o_imem_addr, fe.addr);
               if (fe.lat != 0 && last_fc >= 0)
                  check(cyc - last_fc == fe.lat, "instr_cycles", cyc - last_fc, fe.lat);
            end
            last_fc = cyc;
         end
         if (o_dmem_req && dmem_ack) begin
            if (dacc_q.size() == 0) begin
               check(1'b0, "dmem_unexpected", o_dmem_addr, 0);
            end else begin
               de = dacc_q.pop_front();
               check(o_dmem_we == de.we, "dmem_we", o_dmem_we, de.we);
               check(int'(o_dmem_addr) == de.addr, "dmem_addr", o_dmem_addr, de.addr);
               if (de.we) check(int'(o_dmem_wdata) == de.data, "dmem_wdata", o_dmem_wdata, de.data);
            end
         end
         prev_ireq   = o_imem_req && !im_ack;
         prev_iaddr  = o_imem_addr;
         prev_dreq   = o_dmem_req && !dmem_ack;
         prev_daddr  = o_dmem_addr;
         prev_dwe    = o_dmem_we;
         prev_dwdata = o_dmem_wdata;
      end
   end

   task automatic hold_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check(!o_imem_req && !o_dmem_req && !o_dmem_we && !o_halted, "reset_outputs",
               {o_imem_req, o_dmem_req, o_dmem_we, o_halted}, 0);
      end
      i_rst = 1'b0;
      #1;
      check(o_imem_req == 1'b1 && o_imem_addr == 8'h00 && o_pc == 8'h00, "reset_first_fetch",
            {o_imem_req, o_imem_addr}, 16'h100);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      reset_model();
      hold_reset();
   endtask

   task automatic drain(input string name);
      int n = 0;
      int exp_addr;
      while (delivered < limit && !m_halted && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      while (dacc_q.size() != 0 && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      repeat (4) @(negedge i_clk);
      if (n >= 5000) check(1'b0, {name, "_timeout"}, n, 0);
      if (m_halted) begin
         check(o_halted == 1'b1, {name, "_halted"}, o_halted, 1);
      end else begin
         exp_addr = (fetch_q.size() == 1) ? fetch_q[0].addr : -1;
         check(o_imem_req && int'(o_imem_addr) == exp_addr, {name, "_pending_fetch"},
               o_imem_addr, exp_addr);
      end
   endtask

   task automatic fill_undef();
      for (int i = 0; i < 256; i++) imem[i] = 16'hA000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      i_rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pmem[i]  = 16'($urandom);
         m_mem[i] = int'(pmem[i]);
      end

      // Random programs with random wait states.
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      wait_mode = 0; limit = 300;
      do_reset();
      drain("rand_wait");

      // Random programs with zero-wait memories; instruction latency checked.
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      wait_mode = 1; limit = 200;
      do_reset();
      drain("rand_zero");

      // ALU sequence then halt at PC 4.
      fill_undef();
      imem[0] = 16'h6034;  // LOADC ra,0x34
      imem[1] = 16'h6112;  // LOADC hi ra,0x12
      imem[2] = 16'h0501;  // ADD rb = ra + 1
      imem[3] = 16'h9000;  // STORE [ra] <= rb
      wait_mode = 1; limit = 100;
      do_reset();
      drain("alu_halt");
      check(pmem[8'h34] == 16'h1235, "alu_store_value", pmem[8'h34], 16'h1235);
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         check(!o_imem_req && !o_dmem_req && o_halted && o_pc == 8'h04, "halt_hold",
               {o_imem_req, o_dmem_req, o_halted, o_pc}, 12'h104);
      end

      // Memory traffic with 3-cycle waits on both buses.
      fill_undef();
      imem[0] = 16'h6010;  // LOADC ra,0x10
      imem[1] = 16'h64EF;  // LOADC rb,0xEF
      imem[2] = 16'h65BE;  // LOADC hi rb,0xBE
      imem[3] = 16'h9000;  // STORE
      imem[4] = 16'h8800;  // LOAD rc
      imem[5] = 16'h5600;  // MOVE rb <= rc
      imem[6] = 16'h6020;  // LOADC ra,0x20
      imem[7] = 16'h9000;  // STORE
      wait_mode = 2; limit = 100;
      do_reset();
      drain("mem_wait");
      check(pmem[8'h10] == 16'hBEEF, "store_0x10", pmem[8'h10], 16'hBEEF);
      check(pmem[8'h20] == 16'hBEEF, "load_store_0x20", pmem[8'h20], 16'hBEEF);

      // Jumps and PC wrap from 0xFF to 0x00.
      fill_undef();
      imem[0]     = 16'h6005;  // LOADC ra,0x05
      imem[1]     = 16'h7000;  // JUMP
      imem[5]     = 16'h60FF;  // LOADC ra,0xFF
      imem[6]     = 16'h7000;  // JUMP
      imem[8'hFF] = 16'h0501;  // ADD
      wait_mode = 1; limit = 5;
      do_reset();
      drain("ctrl_flow");
      check(o_imem_addr == 8'h00, "pc_wrap", o_imem_addr, 0);

      // Async reset during a data wait, with a stray ack afterwards.
      fill_undef();
      imem[0] = 16'h8800;  // LOAD rc
      wait_mode = 3; limit = 1;
      do_reset();
      n = 0;
      while (!o_dmem_req && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check(o_dmem_req == 1'b1, "mem_wait_reached", o_dmem_req, 1);
      repeat (3) @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      check(!o_dmem_req && !o_dmem_we && !o_imem_req, "async_reset_drops_req",
            {o_dmem_req, o_dmem_we, o_imem_req}, 0);
      fill_undef();
      imem[0] = 16'h5600;  // MOVE rb <= rc
      imem[1] = 16'h9000;  // STORE [0] <= rb
      wait_mode = 1; limit = 100;
      force_ack = 1'b1;
      reset_model();
      hold_reset();
      repeat (2) @(negedge i_clk);
      force_ack = 1'b0;
      drain("late_ack");
      check(pmem[0] == 16'h0000, "late_ack_ignored", pmem[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
